rv_multicycle_ctrl: RTL and testbench
=====================================

Name: rv_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core. Sequences fetch, decode, execute, memory and writeback over the shared ALU, register file, immediate generator and unified memory port.
- Decodes the latched opcode and drives enables/selects each cycle, including the immediate-format select consumed by the sign extender.
- Handles a req/ready handshake to memory with a bounded wait.

Parameters:
- MEM_WAIT_MAX, 15, max cycles a memory request may stay unacknowledged before bus_err.
- WAIT_W, 4, width of wait counter; must satisfy 2**WAIT_W > MEM_WAIT_MAX.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] from instruction register (valid from DECODE onward)
- funct3  in  3  instr[14:12]
- br_taken  in  1  branch comparator result, valid in EXEC
- mem_ready  in  1  memory acknowledge for current request
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  store when 1 (qualified by mem_req)
- mem_sel_d  out  1  0=address from PC (fetch), 1=ALU result (data access)
- ir_we  out  1  load instruction register
- pc_we  out  1  update PC
- pc_sel  out  2  0=PC+4, 1=ALU target (branch/JAL), 2=ALU&~1 (JALR)
- imm_sel  out  3  ctrl_pkg::imm_t: I, S, B, U, J, NONE
- alu_a_sel  out  1  0=rs1, 1=PC
- alu_b_sel  out  1  0=rs2, 1=immediate
- rf_we  out  1  register file write enable
- wb_sel  out  2  0=ALU, 1=load data, 2=PC+4, 3=immediate (LUI)
- busy  out  1  high in every state except FETCH waiting for issue
- bus_err  out  1  sticky; set on memory timeout

Behaviour:
- Reset: state=FETCH; all outputs 0; imm_sel=NONE; wait counter=0; bus_err cleared. rst mid-transaction drops mem_req on the next edge, with no other side effects.
- States:
  - FETCH: mem_req=1, mem_sel_d=0. On mem_ready: ir_we=1 and go to DECODE.
  - DECODE: set imm_sel from opcode (0010011/0000011/1100111->I, 0100011->S, 1100011->B, 0110111/0010111->U, 1101111->J, 0110011->NONE). Go to EXEC.
  - EXEC: ALU selects per opcode.
    - R/I/LUI/AUIPC go to WB.
    - Load/store go to MEM.
    - Branch: pc_we=br_taken, pc_sel=1 if taken; else pc_we=1, pc_sel=0. Go to FETCH.
    - JAL/JALR go to WB.
  - MEM: mem_req=1, mem_sel_d=1, mem_we=(store). On mem_ready: store goes to FETCH with pc_we=1, pc_sel=0; load goes to WB.
  - WB: rf_we=1 with wb_sel per opcode; pc_we=1. pc_sel=0, except JAL=1 and JALR=2. Go to FETCH.
- All outputs are Moore decodes of state plus the latched opcode, except ir_we/pc_we in FETCH/MEM, which are gated by mem_ready (Mealy).
- Cycle counts with zero-wait memory: ALU op 4, load 5, store 4, branch 3, jump 4.
- Wait counter:
  - Increments each cycle mem_req=1 && mem_ready=0 and clears on accept.
  - Reaching MEM_WAIT_MAX sets bus_err, drops mem_req, and forces FETCH with PC unchanged.
  - Counter saturates and never wraps.
- mem_ready while mem_req=0 is ignored.
- Unknown opcode: treated as NOP. EXEC goes to FETCH with pc_we=1, pc_sel=0, and rf_we is never asserted.

Optional Feature:
- Macro RV_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output trap (1 bit) and state TRAP.
  - Unknown opcode in DECODE goes to TRAP: trap=1, all enables 0, and the FSM stays there until rst.
- Undefined: unknown opcode is a NOP as above; no trap port.

Decomposition:
- ctrl_pkg holds:
  - state_t enum (FETCH, DECODE, EXEC, MEM, WB, TRAP).
  - imm_t enum.
  - Opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC).
  - pc_sel/wb_sel encodings.
- One sub-module, rv_opcode_dec: a combinational opcode to {imm_sel, alu_b_sel, wb_sel, class} table shared with the sign extender's encoding.

Test Plan:
- ADD: opcode 0110011, mem_ready tied 1 -> states F,D,E,W; rf_we=1 in cycle 4 with wb_sel=0; pc_we=1, pc_sel=0; busy drops for one cycle at next FETCH.
- Load with 3 wait cycles: opcode 0000011, mem_ready high on 4th MEM cycle -> mem_req held 4 cycles, imm_sel=I, then WB with wb_sel=1; bus_err=0.
- Taken branch: opcode 1100011, br_taken=1 -> imm_sel=B in DECODE; EXEC pc_we=1, pc_sel=1; rf_we never asserted; 3 cycles total.
- JALR: opcode 1100111 -> WB with wb_sel=2, pc_sel=2, imm_sel=I.
- Timeout: FETCH with mem_ready=0 for 15 cycles -> bus_err=1 on cycle 15, mem_req drops, pc_we never 1.
- Reset mid-MEM: assert rst during a store wait -> next edge state=FETCH, mem_req=0 for one cycle, no pc_we/rf_we; with RV_ILLEGAL_TRAP_EN, opcode 0000000 -> trap=1 held until rst.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control encodings for the multi-cycle RV32I core:
// FSM states, immediate formats, opcode classes and mux selects.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_t;

  typedef enum logic [3:0] {
    CL_R,
    CL_I,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_JALR,
    CL_LUI,
    CL_AUIPC,
    CL_ILL
  } cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

endpackage

// File: rtl/rv_opcode_dec.sv
// Opcode table: immediate format, ALU operand selects, writeback
// source and instruction class. Reserved funct3 encodings decode as illegal.
module rv_opcode_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  output logic [2:0] o_imm_sel,
  output logic       o_alu_a_sel,
  output logic       o_alu_b_sel,
  output logic [1:0] o_wb_sel,
  output logic [3:0] o_cls
);

  imm_t       w_imm;
  cls_t       w_cls;
  logic       w_a;
  logic       w_b;
  logic [1:0] w_wb;
  logic       w_ld_ok;
  logic       w_st_ok;
  logic       w_br_ok;

  assign w_ld_ok = (i_funct3 != 3'b011) && (i_funct3[2:1] != 2'b11);
  assign w_st_ok = (i_funct3[2:1] == 2'b00) || (i_funct3 == 3'b010);
  assign w_br_ok = (i_funct3[2:1] != 2'b01);

  always_comb begin
    w_imm = IMM_NONE;
    w_cls = CL_ILL;
    w_a   = 1'b0;
    w_b   = 1'b0;
    w_wb  = WB_ALU;
    unique case (1'b1)
      (i_opcode == OP_R): w_cls = CL_R;
      (i_opcode == OP_I): begin
        w_cls = CL_I; w_imm = IMM_I; w_b = 1'b1;
      end
      (i_opcode == OP_LOAD): if (w_ld_ok) begin
        w_cls = CL_LOAD; w_imm = IMM_I;
        w_b = 1'b1; w_wb = WB_LOAD;
      end
      (i_opcode == OP_STORE): if (w_st_ok) begin
        w_cls = CL_STORE; w_imm = IMM_S; w_b = 1'b1;
      end
      (i_opcode == OP_BRANCH): if (w_br_ok) begin
        w_cls = CL_BRANCH; w_imm = IMM_B;
        w_a = 1'b1; w_b = 1'b1;
      end
      (i_opcode == OP_JAL): begin
        w_cls = CL_JAL; w_imm = IMM_J;
        w_a = 1'b1; w_b = 1'b1; w_wb = WB_PC4;
      end
      (i_opcode == OP_JALR): if (i_funct3 == 3'b000) begin
        w_cls = CL_JALR; w_imm = IMM_I;
        w_b = 1'b1; w_wb = WB_PC4;
      end
      (i_opcode == OP_LUI): begin
        w_cls = CL_LUI; w_imm = IMM_U;
        w_b = 1'b1; w_wb = WB_IMM;
      end
      (i_opcode == OP_AUIPC): begin
        w_cls = CL_AUIPC; w_imm = IMM_U;
        w_a = 1'b1; w_b = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_imm_sel   = w_imm;
  assign o_alu_a_sel = w_a;
  assign o_alu_b_sel = w_b;
  assign o_wb_sel    = w_wb;
  assign o_cls       = w_cls;

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core with bounded memory wait.
// Define RV_ILLEGAL_TRAP_EN to trap on illegal instructions instead of NOP.
module rv_multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_W       = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_br_taken,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_mem_sel_d,
  output logic       o_ir_we,
  output logic       o_pc_we,
  output logic [1:0] o_pc_sel,
  output logic [2:0] o_imm_sel,
  output logic       o_alu_a_sel,
  output logic       o_alu_b_sel,
  output logic       o_rf_we,
  output logic [1:0] o_wb_sel,
  output logic       o_busy,
  output logic       o_bus_err
`ifdef RV_ILLEGAL_TRAP_EN
  ,
  output logic       o_trap
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MEM_WAIT_MAX);

  state_t            r_state;
  state_t            w_next;
  logic              r_armed;
  logic [WAIT_W-1:0] r_wait;
  logic              r_bus_err;

  logic [2:0] w_imm;
  logic       w_a;
  logic       w_b;
  logic [1:0] w_wb;
  logic [3:0] w_cls_raw;
  cls_t       w_cls;
  logic       w_req;
  logic       w_acc;
  logic       w_tout;

  rv_opcode_dec u_dec (
    .i_opcode    (i_opcode),
    .i_funct3    (i_funct3),
    .o_imm_sel   (w_imm),
    .o_alu_a_sel (w_a),
    .o_alu_b_sel (w_b),
    .o_wb_sel    (w_wb),
    .o_cls       (w_cls_raw)
  );

  assign w_cls = cls_t'(w_cls_raw);

  // After reset or a timeout, FETCH idles one cycle before re-issuing.
  assign w_req  = ((r_state == FETCH) && r_armed) || (r_state == MEM);
  assign w_acc  = w_req && i_mem_ready;
  assign w_tout = w_req && !i_mem_ready && (r_wait == WAIT_LAST);

  assign o_mem_req = w_req;
  assign o_busy    = (r_state != FETCH);
  assign o_bus_err = r_bus_err;
`ifdef RV_ILLEGAL_TRAP_EN
  assign o_trap    = (r_state == TRAP);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= FETCH;
      r_armed   <= 1'b0;
      r_wait    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_armed <= !w_tout;
      if (!w_req || i_mem_ready)
        r_wait <= '0;
      else if (r_wait != WAIT_SAT)
        r_wait <= r_wait + 1'b1;
      if (w_tout)
        r_bus_err <= 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    o_mem_we    = 1'b0;
    o_mem_sel_d = 1'b0;
    o_ir_we     = 1'b0;
    o_pc_we     = 1'b0;
    o_pc_sel    = PC_PLUS4;
    o_imm_sel   = IMM_NONE;
    o_alu_a_sel = 1'b0;
    o_alu_b_sel = 1'b0;
    o_rf_we     = 1'b0;
    o_wb_sel    = WB_ALU;
    unique case (r_state)
      FETCH: if (w_acc) begin
        o_ir_we = 1'b1;
        w_next  = DECODE;
      end
      DECODE: begin
        o_imm_sel = w_imm;
        w_next    = EXEC;
`ifdef RV_ILLEGAL_TRAP_EN
        if (w_cls == CL_ILL) w_next = TRAP;
`endif
      end
      EXEC: begin
        o_imm_sel   = w_imm;
        o_alu_a_sel = w_a;
        o_alu_b_sel = w_b;
        unique case (w_cls)
          CL_LOAD, CL_STORE: w_next = MEM;
          CL_BRANCH: begin
            o_pc_we  = 1'b1;
            o_pc_sel = i_br_taken ? PC_ALU : PC_PLUS4;
            w_next   = FETCH;
          end
          CL_ILL: begin
            o_pc_we = 1'b1;
            w_next  = FETCH;
          end
          default: w_next = WB;
        endcase
      end
      MEM: begin
        o_imm_sel   = w_imm;
        o_mem_sel_d = 1'b1;
        o_mem_we    = (w_cls == CL_STORE);
        if (w_acc) begin
          o_pc_we = (w_cls == CL_STORE);
          w_next  = (w_cls == CL_STORE) ? FETCH : WB;
        end else if (w_tout) begin
          w_next = FETCH;
        end
      end
      WB: begin
        o_imm_sel = w_imm;
        o_rf_we   = 1'b1;
        o_wb_sel  = w_wb;
        o_pc_we   = 1'b1;
        if (w_cls == CL_JAL)  o_pc_sel = PC_ALU;
        if (w_cls == CL_JALR) o_pc_sel = PC_JALR;
        w_next = FETCH;
      end
      TRAP: ;
      default: w_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomized bench for rv_multicycle_ctrl against a cycle-trace model
// built per instruction from the control rules.
module tb_rv_multicycle_ctrl;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       br_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_sel_d, ir_we, pc_we;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] imm_sel;
  logic       alu_a_sel, alu_b_sel, rf_we, busy, bus_err;
`ifdef RV_ILLEGAL_TRAP_EN
  logic       trap;
`endif

  rv_multicycle_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_opcode    (opcode),
    .i_funct3    (funct3),
    .i_br_taken  (br_taken),
    .i_mem_ready (mem_ready),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_sel_d (mem_sel_d),
    .o_ir_we     (ir_we),
    .o_pc_we     (pc_we),
    .o_pc_sel    (pc_sel),
    .o_imm_sel   (imm_sel),
    .o_alu_a_sel (alu_a_sel),
    .o_alu_b_sel (alu_b_sel),
    .o_rf_we     (rf_we),
    .o_wb_sel    (wb_sel),
    .o_busy      (busy),
    .o_bus_err   (bus_err)
`ifdef RV_ILLEGAL_TRAP_EN
    ,
    .o_trap      (trap)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        br;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [16:0] o;
    logic        trp;
    string       tag;
  } cyc_t;

  cyc_t       q[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic       m_err = 1'b0;
  logic [6:0] cur_op = '0;
  logic [2:0] cur_f3 = '0;
  logic [16:0] w_obs;

  assign w_obs = {mem_req, mem_we, mem_sel_d, ir_we, pc_we, pc_sel,
                  imm_sel, alu_a_sel, alu_b_sel, rf_we, wb_sel,
                  busy, bus_err};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom % 2);
  endfunction

  function automatic logic [16:0] pk(
    input logic req, we, sd, ir, pw, input logic [1:0] ps,
    input logic [2:0] im, input logic a, b, rw,
    input logic [1:0] wb, input logic bz);
    return {req, we, sd, ir, pw, ps, im, a, b, rw, wb, bz, m_err};
  endfunction

  function automatic logic [2:0] m_imm(input logic [6:0] op);
    case (op)
      7'h13, 7'h03, 7'h67: return 3'd0;
      7'h23:               return 3'd1;
      7'h63:               return 3'd2;
      7'h37, 7'h17:        return 3'd3;
      7'h6f:               return 3'd4;
      default:             return 3'd5;
    endcase
  endfunction

  function automatic logic m_known(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                      7'h6f, 7'h67, 7'h37, 7'h17};
  endfunction

  function automatic logic [2:0] f3_for(input logic [6:0] op);
    logic [2:0] f;
    f = 3'($urandom % 8);
    case (op)
      7'h03: while (f == 3 || f > 5) f = 3'($urandom % 8);
      7'h23: f = 3'($urandom % 3);
      7'h63: while (f == 2 || f == 3) f = 3'($urandom % 8);
      7'h67: f = 3'd0;
      default: ;
    endcase
    return f;
  endfunction

  task automatic push(input logic rdy, input logic br,
                      input logic [16:0] o, input logic trp,
                      input string tag);
    cyc_t c;
    c.rdy = rdy; c.br = br; c.op = cur_op; c.f3 = cur_f3;
    c.o = o; c.trp = trp; c.tag = tag;
    q.push_back(c);
  endtask

  task automatic add_idle(input string tg);
    push(rb(), rb(), pk(0,0,0,0,0,0,3'd5,0,0,0,0,0), 1'b0, tg);
  endtask

  task automatic add_fetch(input int fw, input string tg);
    for (int k = 0; k < fw; k++)
      push(1'b0, rb(), pk(1,0,0,0,0,0,3'd5,0,0,0,0,0), 1'b0,
           {tg, ".fwait"});
    push(1'b1, rb(), pk(1,0,0,1,0,0,3'd5,0,0,0,0,0), 1'b0,
         {tg, ".fetch"});
  endtask

  task automatic add_timeout(input logic in_mem, input string tg);
    logic st;
    st = (cur_op == 7'h23);
    for (int k = 0; k < TO; k++) begin
      if (in_mem)
        push(1'b0, rb(), pk(1,st,1,0,0,0,m_imm(cur_op),0,0,0,0,1),
             1'b0, {tg, ".to"});
      else
        push(1'b0, rb(), pk(1,0,0,0,0,0,3'd5,0,0,0,0,0),
             1'b0, {tg, ".to"});
    end
    m_err = 1'b1;
    add_idle({tg, ".drop"});
  endtask

  // Expected trace of one instruction; mw<0 means the data access times out,
  // stop cuts the trace during the data wait.
  task automatic add_instr(input logic [6:0] op, input int fw,
                           input int mw, input int brv,
                           input logic stop, input string tg);
    logic [2:0] im;
    logic       a, b, st, br;
    logic [1:0] ps, wb;
    cur_op = op;
    cur_f3 = f3_for(op);
    im = m_imm(op);
    a  = op inside {7'h17, 7'h6f, 7'h63};
    b  = m_known(op) && op != 7'h33;
    st = (op == 7'h23);
    add_fetch(fw, tg);
    push(rb(), rb(), pk(0,0,0,0,0,0,im,0,0,0,0,1), 1'b0, {tg, ".dec"});
`ifdef RV_ILLEGAL_TRAP_EN
    if (!m_known(op)) begin
      for (int k = 0; k < 6; k++)
        push(rb(), rb(), pk(0,0,0,0,0,0,3'd5,0,0,0,0,1), 1'b1,
             {tg, ".trap"});
      return;
    end
`endif
    br = (brv < 0) ? rb() : 1'(brv);
    if (op == 7'h63) begin
      push(rb(), br, pk(0,0,0,0,1,{1'b0, br},im,a,b,0,0,1), 1'b0,
           {tg, ".exb"});
      return;
    end
    if (!m_known(op)) begin
      push(rb(), br, pk(0,0,0,0,1,0,3'd5,0,0,0,0,1), 1'b0,
           {tg, ".nop"});
      return;
    end
    push(rb(), br, pk(0,0,0,0,0,0,im,a,b,0,0,1), 1'b0, {tg, ".ex"});
    if (op == 7'h03 || st) begin
      if (mw < 0) begin
        add_timeout(1'b1, tg);
        return;
      end
      for (int k = 0; k < mw; k++)
        push(1'b0, rb(), pk(1,st,1,0,0,0,im,0,0,0,0,1), 1'b0,
             {tg, ".mwait"});
      if (stop) return;
      push(1'b1, rb(), pk(1,st,1,0,st,0,im,0,0,0,0,1), 1'b0,
           {tg, ".mem"});
      if (st) return;
    end
    ps = (op == 7'h6f) ? 2'd1 : (op == 7'h67) ? 2'd2 : 2'd0;
    wb = (op == 7'h03) ? 2'd1 :
         (op == 7'h6f || op == 7'h67) ? 2'd2 :
         (op == 7'h37) ? 2'd3 : 2'd0;
    push(rb(), rb(), pk(0,0,0,0,1,ps,im,0,0,1,wb,1), 1'b0, {tg, ".wb"});
  endtask

  task automatic run_q();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      opcode    = c.op;
      funct3    = c.f3;
      mem_ready = c.rdy;
      br_taken  = c.br;
      @(negedge clk);
      check(c.tag, {15'd0, w_obs}, {15'd0, c.o});
`ifdef RV_ILLEGAL_TRAP_EN
      check({c.tag, ".trapbit"}, {31'd0, trap}, {31'd0, c.trp});
`endif
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tg);
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_err = 1'b0;
    add_idle(tg);
    run_q();
  endtask

  logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f,
                           7'h67, 7'h37, 7'h17, 7'h00, 7'h0b, 7'h7f};

  initial begin
    int nops;
`ifdef RV_ILLEGAL_TRAP_EN
    nops = 9;
`else
    nops = 12;
`endif
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    add_instr(7'h33, 0, 0, -1, 1'b0, "add");
    add_instr(7'h03, 0, 3, -1, 1'b0, "load3");
    add_instr(7'h63, 0, 0, 1, 1'b0, "beq_t");
    add_instr(7'h63, 1, 0, 0, 1'b0, "beq_n");
    add_instr(7'h67, 0, 0, -1, 1'b0, "jalr");
    add_instr(7'h23, 2, 1, -1, 1'b0, "store");
    add_instr(7'h6f, 0, 0, -1, 1'b0, "jal");
    add_instr(7'h37, 0, 0, -1, 1'b0, "lui");
    add_instr(7'h17, 0, 0, -1, 1'b0, "auipc");
`ifndef RV_ILLEGAL_TRAP_EN
    add_instr(7'h00, 0, 0, -1, 1'b0, "illnop");
`endif
    run_q();

    cur_op = 7'h33;
    add_timeout(1'b0, "ftime");
    add_instr(7'h33, 1, 0, -1, 1'b0, "add_err");
    run_q();
    do_reset("rst_clr");

    add_instr(7'h03, 0, -1, -1, 1'b0, "mtime");
    run_q();
    do_reset("rst_mt");

    add_instr(7'h23, 0, 2, -1, 1'b1, "st_cut");
    run_q();
    do_reset("rst_mid");

    for (int i = 0; i < 200; i++) begin
      add_instr(ops[$urandom % nops], int'($urandom % 4),
                int'($urandom % 4), -1, 1'b0, $sformatf("r%0d", i));
      run_q();
    end

`ifdef RV_ILLEGAL_TRAP_EN
    add_instr(7'h00, 0, 0, -1, 1'b0, "trap");
    run_q();
    do_reset("rst_trap");
    add_instr(7'h33, 0, 0, -1, 1'b0, "add_post");
    run_q();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
